// File: rtl/lcd_bus_capture.sv
// Passive receiver for the HD44780-style LCD write bus.
// Decodes each write and mirrors the visible 2x16 characters into a 32-byte shadow buffer.
module lcd_bus_capture #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        CLOCK_50,
   input  logic        RESET,
   input  logic [9:0]  lcdcontrol,
   input  logic [4:0]  rd_idx,
   output logic [7:0]  rd_char,
   output logic        cmd_valid,
   output logic        data_valid,
   output logic [7:0]  bus_byte,
   output logic [6:0]  cursor,
   output logic        display_on,
   output logic        entry_inc,
   output logic        func_8bit,
   output logic        func_2line,
   output logic        busy,
   output logic        overrun,
   output logic [15:0] data_count
);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t      state_q, state_d;
   logic [9:0]  sync_q [SYNC_STAGES];
   logic [9:0]  sync_d [SYNC_STAGES];
   logic        prev_e_q, prev_e_d;
   logic [5:0]  clr_idx_q, clr_idx_d;
   logic [6:0]  cursor_q, cursor_d;
   logic        cg_mode_q, cg_mode_d;
   logic        display_on_q, display_on_d;
   logic        entry_inc_q, entry_inc_d;
   logic        func_8bit_q, func_8bit_d;
   logic        func_2line_q, func_2line_d;
   logic [7:0]  bus_byte_q, bus_byte_d;
   logic [15:0] data_count_q, data_count_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic        data_valid_q, data_valid_d;
   logic        overrun_q, overrun_d;
   logic [7:0]  rd_char_q, rd_char_d;
   logic [7:0]  shadow_q [32];

   logic        wr_en;
   logic [4:0]  wr_idx;
   logic [7:0]  wr_data;
   logic [9:0]  bus_word;
   logic        e_fall;

   // DDRAM address walk: the two visible row windows are stitched end to end.
   function automatic logic [6:0] step_cursor(input logic [6:0] c, input logic inc);
      if (inc) begin
         if (c == 7'h27)      return 7'h40;
         else if (c == 7'h67) return 7'h00;
         else                 return c + 7'd1;
      end else begin
         if (c == 7'h40)      return 7'h27;
         else if (c == 7'h00) return 7'h67;
         else                 return c - 7'd1;
      end
   endfunction

   assign bus_word = sync_q[SYNC_STAGES-1];
   assign e_fall   = prev_e_q & ~bus_word[1];

   always_comb begin
      sync_d[0] = lcdcontrol;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_comb begin
      state_d      = state_q;
      prev_e_d     = bus_word[1];
      clr_idx_d    = clr_idx_q;
      cursor_d     = cursor_q;
      cg_mode_d    = cg_mode_q;
      display_on_d = display_on_q;
      entry_inc_d  = entry_inc_q;
      func_8bit_d  = func_8bit_q;
      func_2line_d = func_2line_q;
      bus_byte_d   = bus_byte_q;
      data_count_d = data_count_q;
      cmd_valid_d  = 1'b0;
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
      rd_char_d    = shadow_q[rd_idx];
      wr_en        = 1'b0;
      wr_idx       = clr_idx_q[4:0];
      wr_data      = 8'h20;

      if (state_q == ST_CLEAR) begin
         if (clr_idx_q[5]) begin
            state_d = ST_IDLE;
         end else begin
            wr_en     = 1'b1;
            clr_idx_d = clr_idx_q + 6'd1;
         end
      end

      // Writes landing during the clear fill are dropped; only the overrun pulse reports them.
      if (e_fall) begin
         if (state_q == ST_CLEAR) begin
            overrun_d = 1'b1;
         end else begin
            bus_byte_d = bus_word[9:2];
            if (!bus_word[0]) begin
               cmd_valid_d = 1'b1;
               casez (bus_word[9:2])
                  8'b1???????: begin
                     cursor_d  = bus_word[8:2];
                     cg_mode_d = 1'b0;
                  end
                  8'b01??????: cg_mode_d = 1'b1;
                  8'b001?????: begin
                     func_8bit_d  = bus_word[6];
                     func_2line_d = bus_word[5];
                  end
                  8'b00001???: display_on_d = bus_word[4];
                  8'b000001??: entry_inc_d  = bus_word[3];
                  8'b0000001?: cursor_d     = 7'h00;
                  8'b00000001: begin
                     cursor_d    = 7'h00;
                     entry_inc_d = 1'b1;
                     cg_mode_d   = 1'b0;
                     state_d     = ST_CLEAR;
                     clr_idx_d   = 6'd0;
                  end
                  default: ;
               endcase
            end else begin
               data_valid_d = 1'b1;
               if (data_count_q != 16'hFFFF) begin
                  data_count_d = data_count_q + 16'd1;
               end
               if (!cg_mode_q && (cursor_q[6:4] == 3'b000 || cursor_q[6:4] == 3'b100)) begin
                  wr_en   = 1'b1;
                  wr_idx  = {cursor_q[6], cursor_q[3:0]};
                  wr_data = bus_word[9:2];
               end
               cursor_d = step_cursor(cursor_q, entry_inc_q);
            end
         end
      end
   end

   // Reset parks the block in the clear state so the fill starts on the first free cycle.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         state_q      <= ST_CLEAR;
         prev_e_q     <= 1'b0;
         clr_idx_q    <= 6'd0;
         cursor_q     <= 7'h00;
         cg_mode_q    <= 1'b0;
         display_on_q <= 1'b0;
         entry_inc_q  <= 1'b1;
         func_8bit_q  <= 1'b0;
         func_2line_q <= 1'b0;
         bus_byte_q   <= 8'h00;
         data_count_q <= 16'h0000;
         cmd_valid_q  <= 1'b0;
         data_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         rd_char_q    <= 8'h00;
      end else begin
         sync_q       <= sync_d;
         state_q      <= state_d;
         prev_e_q     <= prev_e_d;
         clr_idx_q    <= clr_idx_d;
         cursor_q     <= cursor_d;
         cg_mode_q    <= cg_mode_d;
         display_on_q <= display_on_d;
         entry_inc_q  <= entry_inc_d;
         func_8bit_q  <= func_8bit_d;
         func_2line_q <= func_2line_d;
         bus_byte_q   <= bus_byte_d;
         data_count_q <= data_count_d;
         cmd_valid_q  <= cmd_valid_d;
         data_valid_q <= data_valid_d;
         overrun_q    <= overrun_d;
         rd_char_q    <= rd_char_d;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (wr_en && !RESET) begin
         shadow_q[wr_idx] <= wr_data;
      end
   end

   assign rd_char    = rd_char_q;
   assign cmd_valid  = cmd_valid_q;
   assign data_valid = data_valid_q;
   assign bus_byte   = bus_byte_q;
   assign cursor     = cursor_q;
   assign display_on = display_on_q;
   assign entry_inc  = entry_inc_q;
   assign func_8bit  = func_8bit_q;
   assign func_2line = func_2line_q;
   assign busy       = (state_q == ST_CLEAR);
   assign overrun    = overrun_q;
   assign data_count = data_count_q;

endmodule

// File: tb/tb_lcd_bus_capture.sv
// Self-checking bench for lcd_bus_capture: an edge-counting behavioural model
// compared against the DUT every cycle, plus literal expectations for the main scenarios.
module tb_lcd_bus_capture;

   localparam int SYNC_STAGES = 2;

   logic        CLOCK_50 = 1'b0;
   logic        RESET = 1'b1;
   logic [9:0]  lcdcontrol = 10'h000;
   logic [4:0]  rd_idx = 5'd0;
   logic [7:0]  rd_char;
   logic        cmd_valid;
   logic        data_valid;
   logic [7:0]  bus_byte;
   logic [6:0]  cursor;
   logic        display_on;
   logic        entry_inc;
   logic        func_8bit;
   logic        func_2line;
   logic        busy;
   logic        overrun;
   logic [15:0] data_count;

   lcd_bus_capture #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .CLOCK_50   (CLOCK_50),
      .RESET      (RESET),
      .lcdcontrol (lcdcontrol),
      .rd_idx     (rd_idx),
      .rd_char    (rd_char),
      .cmd_valid  (cmd_valid),
      .data_valid (data_valid),
      .bus_byte   (bus_byte),
      .cursor     (cursor),
      .display_on (display_on),
      .entry_inc  (entry_inc),
      .func_8bit  (func_8bit),
      .func_2line (func_2line),
      .busy       (busy),
      .overrun    (overrun),
      .data_count (data_count)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      int         due;
      bit         rs;
      logic [7:0] b;
   } wr_t;

   wr_t pend[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int clr_start = -1000;
   int ovr_seen = 0;
   bit check_on = 1'b0;

   logic [7:0] m_buf [32];
   bit         m_known [32];
   logic [6:0] m_cursor;
   bit         m_entry, m_disp, m_f8, m_f2, m_cg;
   bit         m_cmdv, m_datav, m_ovr, m_busy;
   logic [7:0] m_byte;
   logic [7:0] m_rd;
   bit         m_rd_known;
   int         m_count;
   int         m_d;
   bit         m_busy_before;
   wr_t        m_w;

   initial begin
      for (int i = 0; i < 32; i++) m_known[i] = 1'b0;
   end

   task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [6:0] nextCursor(input logic [6:0] c, input bit inc);
      int v;
      if (inc) begin
         if (c == 7'h27) return 7'h40;
         if (c == 7'h67) return 7'h00;
         v = (int'(c) + 1) % 128;
      end else begin
         if (c == 7'h40) return 7'h27;
         if (c == 7'h00) return 7'h67;
         v = (int'(c) + 127) % 128;
      end
      return 7'(v);
   endfunction

   task automatic modelWrite(input wr_t w);
      int h;
      int addr;
      m_byte = w.b;
      if (!w.rs) begin
         m_cmdv = 1'b1;
         h = -1;
         for (int i = 7; i >= 0; i--) begin
            if (w.b[i] && h < 0) h = i;
         end
         case (h)
            7: begin m_cursor = w.b[6:0]; m_cg = 1'b0; end
            6: m_cg = 1'b1;
            5: begin m_f8 = w.b[4]; m_f2 = w.b[3]; end
            3: m_disp = w.b[2];
            2: m_entry = w.b[1];
            1: m_cursor = 7'h00;
            0: begin
               m_cursor = 7'h00; m_entry = 1'b1; m_cg = 1'b0; clr_start = cyc;
            end
            default: ;
         endcase
      end else begin
         m_datav = 1'b1;
         if (m_count < 65535) m_count++;
         addr = int'(m_cursor);
         if (!m_cg && addr <= 'h0F) begin
            m_buf[addr] = w.b; m_known[addr] = 1'b1;
         end else if (!m_cg && addr >= 'h40 && addr <= 'h4F) begin
            m_buf[16 + addr - 'h40] = w.b; m_known[16 + addr - 'h40] = 1'b1;
         end
         m_cursor = nextCursor(m_cursor, m_entry);
      end
   endtask

   // Model: counts rising edges and applies each decoded write on its due edge.
   always @(posedge CLOCK_50) begin
      cyc++;
      m_cmdv = 1'b0; m_datav = 1'b0; m_ovr = 1'b0;
      if (RESET) begin
         m_cursor = 7'h00; m_entry = 1'b1; m_disp = 1'b0; m_f8 = 1'b0; m_f2 = 1'b0;
         m_cg = 1'b0; m_byte = 8'h00; m_count = 0; m_rd = 8'h00; m_rd_known = 1'b1;
         clr_start = cyc;
         pend.delete();
      end else begin
         m_rd = m_buf[rd_idx];
         m_rd_known = m_known[rd_idx];
         m_busy_before = (cyc - 1 - clr_start) <= 32;
         m_d = cyc - clr_start;
         if (m_d >= 1 && m_d <= 32) begin
            m_buf[m_d-1] = 8'h20; m_known[m_d-1] = 1'b1;
         end
         if (pend.size() > 0 && pend[0].due == cyc) begin
            m_w = pend.pop_front();
            if (m_busy_before) m_ovr = 1'b1;
            else modelWrite(m_w);
         end
      end
      m_busy = (cyc - clr_start) <= 32;
   end

   task automatic checkOutput();
      checkValue("cmd_valid", 16'(cmd_valid), 16'(m_cmdv));
      checkValue("data_valid", 16'(data_valid), 16'(m_datav));
      checkValue("overrun", 16'(overrun), 16'(m_ovr));
      checkValue("bus_byte", 16'(bus_byte), 16'(m_byte));
      checkValue("cursor", 16'(cursor), 16'(m_cursor));
      checkValue("display_on", 16'(display_on), 16'(m_disp));
      checkValue("entry_inc", 16'(entry_inc), 16'(m_entry));
      checkValue("func_8bit", 16'(func_8bit), 16'(m_f8));
      checkValue("func_2line", 16'(func_2line), 16'(m_f2));
      checkValue("busy", 16'(busy), 16'(m_busy));
      checkValue("data_count", data_count, 16'(m_count));
      if (m_rd_known) checkValue("rd_char", 16'(rd_char), 16'(m_rd));
   endtask

   always @(negedge CLOCK_50) begin
      if (check_on) begin
         checkOutput();
         if (overrun === 1'b1) ovr_seen++;
      end
   end

   // One bus write: E high for `high` cycles, then E falls with data held for `low` cycles.
   task automatic applyStimulus(input bit rs, input logic [7:0] b, input int high, input int low);
      wr_t w;
      @(negedge CLOCK_50);
      lcdcontrol = {b, 1'b1, rs};
      repeat (high) @(negedge CLOCK_50);
      lcdcontrol[1] = 1'b0;
      w.due = cyc + 1 + SYNC_STAGES;
      w.rs = rs;
      w.b = b;
      pend.push_back(w);
      repeat (low) @(negedge CLOCK_50);
   endtask

   task automatic readIdx(input int i, output logic [7:0] v);
      @(negedge CLOCK_50);
      rd_idx = 5'(i);
      @(negedge CLOCK_50);
      v = rd_char;
   endtask

   task automatic readAllSpaces(input string name);
      logic [7:0] v;
      for (int i = 0; i < 32; i++) begin
         readIdx(i, v);
         checkValue(name, 16'(v), 16'h0020);
      end
   endtask

   task automatic releaseAndTimeBusy(input string name);
      int busy_cnt;
      busy_cnt = 0;
      RESET = 1'b0;
      repeat (40) begin
         @(negedge CLOCK_50);
         if (busy === 1'b1) busy_cnt++;
      end
      checkValue(name, 16'(busy_cnt), 16'd32);
   endtask

   initial begin
      logic [7:0] v;
      repeat (3) @(negedge CLOCK_50);
      check_on = 1'b1;
      releaseAndTimeBusy("reset_busy_len");
      readAllSpaces("reset_fill");
      checkValue("reset_cursor", 16'(cursor), 16'h0000);
      checkValue("reset_entry_inc", 16'(entry_inc), 16'h0001);

      applyStimulus(1'b0, 8'h38, 3, 3);
      applyStimulus(1'b0, 8'h0C, 3, 3);
      applyStimulus(1'b0, 8'h06, 3, 3);
      checkValue("func_8bit_set", 16'(func_8bit), 16'h0001);
      checkValue("func_2line_set", 16'(func_2line), 16'h0001);
      checkValue("display_on_set", 16'(display_on), 16'h0001);

      applyStimulus(1'b0, 8'h80, 3, 3);
      applyStimulus(1'b1, 8'h58, 3, 3);
      applyStimulus(1'b1, 8'h3A, 3, 3);
      readIdx(0, v); checkValue("row0_col0", 16'(v), 16'h0058);
      readIdx(1, v); checkValue("row0_col1", 16'(v), 16'h003A);
      checkValue("cursor_after_2", 16'(cursor), 16'h0002);
      checkValue("count_after_2", data_count, 16'd2);

      applyStimulus(1'b0, 8'hC0, 3, 3);
      for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(8'h61 + i), 3, 2);
      readIdx(16, v); checkValue("row1_col0", 16'(v), 16'h0061);
      readIdx(31, v); checkValue("row1_col15", 16'(v), 16'h0070);
      checkValue("cursor_row1_end", 16'(cursor), 16'h0051);
      checkValue("count_after_19", data_count, 16'd19);

      applyStimulus(1'b0, 8'hA7, 3, 3);
      applyStimulus(1'b0, 8'h06, 3, 3);
      applyStimulus(1'b1, 8'h41, 3, 3);
      checkValue("cursor_wrap_27", 16'(cursor), 16'h0040);
      applyStimulus(1'b0, 8'h80, 3, 3);
      applyStimulus(1'b0, 8'h04, 3, 3);
      applyStimulus(1'b1, 8'h42, 3, 3);
      checkValue("cursor_wrap_00", 16'(cursor), 16'h0067);
      readIdx(0, v); checkValue("dec_store", 16'(v), 16'h0042);

      applyStimulus(1'b0, 8'h40, 3, 3);
      applyStimulus(1'b1, 8'h55, 3, 3);
      readIdx(0, v); checkValue("cg_discard", 16'(v), 16'h0042);
      checkValue("cg_counted", data_count, 16'd22);
      applyStimulus(1'b0, 8'h10, 3, 3);
      applyStimulus(1'b0, 8'h20, 3, 3);
      checkValue("func_8bit_clr", 16'(func_8bit), 16'h0000);
      applyStimulus(1'b0, 8'h02, 3, 3);
      checkValue("home_cursor", 16'(cursor), 16'h0000);
      applyStimulus(1'b0, 8'h00, 3, 3);

      // E held high with the data lines wandering must not decode anything.
      @(negedge CLOCK_50);
      lcdcontrol = {8'hFF, 1'b1, 1'b0};
      repeat (6) @(negedge CLOCK_50);
      lcdcontrol[9:2] = 8'h13;
      repeat (6) @(negedge CLOCK_50);
      checkValue("no_false_edge", data_count, 16'd22);
      applyStimulus(1'b0, 8'h80, 3, 3);
      applyStimulus(1'b1, 8'h33, 3, 3);
      readIdx(0, v); checkValue("cg_exit_store", 16'(v), 16'h0033);

      ovr_seen = 0;
      applyStimulus(1'b0, 8'h01, 3, 2);
      applyStimulus(1'b1, 8'h5A, 2, 3);
      repeat (35) @(negedge CLOCK_50);
      checkValue("overrun_pulses", 16'(ovr_seen), 16'd1);
      checkValue("overrun_count", data_count, 16'd23);
      checkValue("clear_cursor", 16'(cursor), 16'h0000);
      readAllSpaces("clear_fill");

      applyStimulus(1'b0, 8'h01, 3, 3);
      repeat (10) @(negedge CLOCK_50);
      RESET = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      releaseAndTimeBusy("restart_busy_len");
      checkValue("restart_count", data_count, 16'd0);
      readAllSpaces("restart_fill");

      checkValue("pending_drained", 16'(pend.size()), 16'd0);
      check_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
